// File: rtl/filter_px_feeder.sv
// filter_px_feeder: feeds RGB565 pixels one at a time to a line filter, returns its result to the sink.
// Latency 3 cycles from src accept to out_valid, 1 px / 4 cycles max; out_ready low holds output and keeps src_ready low.
module filter_px_feeder #(
    parameter int BLOCK_LENGTH = 720,
    parameter int RDY_TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] src_data,
    input  logic        src_valid,
    output logic        src_ready,
    output logic [15:0] f_d_in,
    output logic        f_wren,
    output logic [9:0]  f_cursor,
    input  logic [15:0] f_d_out,
    input  logic        f_d_rdy,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        line_done,
    output logic [9:0]  line_cnt,
    output logic        err
);

    localparam int TMO_W = (RDY_TIMEOUT > 1) ? $clog2(RDY_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RDY_TIMEOUT - 1);
    localparam logic [9:0]       CUR_LAST = 10'(BLOCK_LENGTH - 1);

    typedef enum logic [1:0] {IDLE, WRITE, WAIT_RDY, HOLD_OUT} state_t;

    state_t             state_q, state_d;
    logic               src_ready_q, src_ready_d;
    logic [15:0]        f_d_in_q, f_d_in_d;
    logic               f_wren_q, f_wren_d;
    logic [9:0]         cursor_q, cursor_d;
    logic [15:0]        out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               line_done_q, line_done_d;
    logic [9:0]         line_cnt_q, line_cnt_d;
    logic               err_q, err_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;

    always_comb begin
        state_d     = state_q;
        f_d_in_d    = f_d_in_q;
        f_wren_d    = 1'b0;
        cursor_d    = cursor_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        line_done_d = 1'b0;
        line_cnt_d  = line_cnt_q;
        err_d       = err_q;
        tmo_d       = tmo_q;

        case (state_q)
            IDLE: begin
                // src_ready_q gates acceptance so the first cycle after reset cannot take a pixel
                if (src_valid && src_ready_q) begin
                    f_d_in_d = src_data;
                    f_wren_d = 1'b1;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                tmo_d   = '0;
                state_d = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (f_d_rdy) begin
                    out_data_d  = f_d_out;
                    out_valid_d = 1'b1;
                    state_d     = HOLD_OUT;
                end else if (tmo_q == TMO_LAST) begin
                    err_d       = 1'b1;
                    out_data_d  = 16'h0000;
                    out_valid_d = 1'b1;
                    state_d     = HOLD_OUT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            HOLD_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    tmo_d       = '0;
                    state_d     = IDLE;
                    if (cursor_q == CUR_LAST) begin
                        cursor_d    = 10'd0;
                        line_done_d = 1'b1;
                        line_cnt_d  = line_cnt_q + 10'd1;
                    end else begin
                        cursor_d = cursor_q + 10'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        src_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            src_ready_q <= 1'b0;
            f_d_in_q    <= 16'h0000;
            f_wren_q    <= 1'b0;
            cursor_q    <= 10'd0;
            out_data_q  <= 16'h0000;
            out_valid_q <= 1'b0;
            line_done_q <= 1'b0;
            line_cnt_q  <= 10'd0;
            err_q       <= 1'b0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            src_ready_q <= src_ready_d;
            f_d_in_q    <= f_d_in_d;
            f_wren_q    <= f_wren_d;
            cursor_q    <= cursor_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            line_done_q <= line_done_d;
            line_cnt_q  <= line_cnt_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
        end
    end

    assign src_ready = src_ready_q;
    assign f_d_in    = f_d_in_q;
    assign f_wren    = f_wren_q;
    assign f_cursor  = cursor_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign line_done = line_done_q;
    assign line_cnt  = line_cnt_q;
    assign err       = err_q;

endmodule

// File: tb/tb_filter_px_feeder.sv
// Testbench for filter_px_feeder: directed steps with randomized pixel data and timing.
module tb_filter_px_feeder;

    localparam int BL  = 720;
    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] src_data;
    logic        src_valid;
    logic        src_ready;
    logic [15:0] f_d_in;
    logic        f_wren;
    logic [9:0]  f_cursor;
    logic [15:0] f_d_out;
    logic        f_d_rdy;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        line_done;
    logic [9:0]  line_cnt;
    logic        err;

    always #5 clk = ~clk;

    filter_px_feeder #(.BLOCK_LENGTH(BL), .RDY_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .f_d_in(f_d_in), .f_wren(f_wren), .f_cursor(f_cursor),
        .f_d_out(f_d_out), .f_d_rdy(f_d_rdy),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .line_done(line_done), .line_cnt(line_cnt), .err(err)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: pixel column, completed lines, sticky error
    int exp_cur   = 0;
    int exp_lines = 0;
    bit exp_err   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        src_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            f_d_rdy = 1'($urandom_range(0, 1));
            f_d_out = 16'($urandom);
            tick();
            chk("idle_out_valid", 32'(out_valid), 0);
            chk("idle_src_ready", 32'(src_ready), 1);
            chk("idle_wren", 32'(f_wren), 0);
            chk("idle_cursor", 32'(f_cursor), exp_cur);
        end
        f_d_rdy = 1'b0;
    endtask

    // One pixel end to end; rdy_after = WAIT_RDY cycles before f_d_rdy (>= TMO means never)
    task automatic run_pixel(input logic [15:0] d, input int rdy_after, input int hold,
                             input logic [15:0] fout);
        logic [15:0] exp_out;
        bit          wrapped;
        bit          done;
        exp_out = 16'h0000;
        chk("accept_src_ready", 32'(src_ready), 1);
        src_valid = 1'b1;
        src_data  = d;
        f_d_rdy   = 1'($urandom_range(0, 1));
        f_d_out   = 16'($urandom);
        tick();
        src_valid = 1'b0;
        src_data  = 16'($urandom);
        chk("write_wren", 32'(f_wren), 1);
        chk("write_cursor", 32'(f_cursor), exp_cur);
        chk("write_d_in", 32'(f_d_in), 32'(d));
        chk("write_src_ready", 32'(src_ready), 0);
        chk("write_out_valid", 32'(out_valid), 0);
        chk("write_line_done", 32'(line_done), 0);
        f_d_rdy = 1'b1;
        f_d_out = 16'($urandom);
        tick();
        chk("wait_wren", 32'(f_wren), 0);
        chk("wait_out_valid", 32'(out_valid), 0);
        done = 1'b0;
        for (int w = 0; w < TMO && !done; w++) begin
            if (w == rdy_after) begin
                f_d_rdy = 1'b1;
                f_d_out = fout;
            end else begin
                f_d_rdy = 1'b0;
                f_d_out = 16'($urandom);
            end
            tick();
            if (w == rdy_after) begin
                exp_out = fout;
                done    = 1'b1;
            end else if (w == TMO - 1) begin
                exp_out = 16'h0000;
                exp_err = 1'b1;
                done    = 1'b1;
            end else begin
                chk("wait_loop_out_valid", 32'(out_valid), 0);
                chk("wait_loop_wren", 32'(f_wren), 0);
                chk("wait_loop_cursor", 32'(f_cursor), exp_cur);
                chk("wait_loop_d_in", 32'(f_d_in), 32'(d));
            end
        end
        f_d_rdy = 1'b0;
        chk("out_valid_rise", 32'(out_valid), 1);
        chk("out_data", 32'(out_data), 32'(exp_out));
        chk("err_flag", 32'(err), 32'(exp_err));
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_out_valid", 32'(out_valid), 1);
            chk("hold_out_data", 32'(out_data), 32'(exp_out));
            chk("hold_src_ready", 32'(src_ready), 0);
            chk("hold_wren", 32'(f_wren), 0);
            chk("hold_cursor", 32'(f_cursor), exp_cur);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        wrapped = (exp_cur == BL - 1);
        exp_cur = (exp_cur + 1) % BL;
        if (wrapped) exp_lines = (exp_lines + 1) % 1024;
        chk("done_out_valid", 32'(out_valid), 0);
        chk("done_src_ready", 32'(src_ready), 1);
        chk("done_cursor", 32'(f_cursor), exp_cur);
        chk("done_line_done", 32'(line_done), 32'(wrapped));
        chk("done_line_cnt", 32'(line_cnt), exp_lines);
        chk("done_err", 32'(err), 32'(exp_err));
    endtask

    initial begin
        reset     = 1'b0;
        src_data  = 16'h0000;
        src_valid = 1'b0;
        f_d_out   = 16'h0000;
        f_d_rdy   = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_src_ready", 32'(src_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_wren", 32'(f_wren), 0);
        chk("rst_cursor", 32'(f_cursor), 0);
        chk("rst_line_cnt", 32'(line_cnt), 0);
        chk("rst_line_done", 32'(line_done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_d_in", 32'(f_d_in), 0);

        reset = 1'b1;
        tick();
        chk("release_src_ready", 32'(src_ready), 1);
        idle_cycles(4);

        // Single known pixel, minimum latency
        run_pixel(16'h1234, 0, 0, 16'hABCD);
        chk("single_cursor_after", 32'(f_cursor), 1);

        // Backpressure for 10 cycles
        run_pixel(16'($urandom), 1, 10, 16'($urandom));

        // Filter never ready -> timeout, then a normal pixel keeps err set
        run_pixel(16'($urandom), 99, 2, 16'hFFFF);
        chk("timeout_err_set", 32'(err), 1);
        run_pixel(16'($urandom), 0, 0, 16'h5A5A);
        chk("err_sticky", 32'(err), 1);

        // Rest of the line with random data and timing
        for (int p = 4; p < BL; p++) begin
            run_pixel(16'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                      16'($urandom));
            if ((p % 97) == 0) idle_cycles(2);
        end
        chk("line_cnt_after_line", 32'(line_cnt), 1);
        chk("cursor_after_line", 32'(f_cursor), 0);

        for (int p = 0; p < 5; p++)
            run_pixel(16'($urandom), int'($urandom_range(0, 2)), 0, 16'($urandom));

        // Reset while holding output at column 5
        src_valid = 1'b1;
        src_data  = 16'h0BAD;
        tick();
        src_valid = 1'b0;
        tick();
        f_d_rdy = 1'b1;
        f_d_out = 16'hBEEF;
        tick();
        f_d_rdy = 1'b0;
        chk("pre_rst_out_valid", 32'(out_valid), 1);
        chk("pre_rst_cursor", 32'(f_cursor), 5);
        reset = 1'b0;
        tick();
        exp_cur   = 0;
        exp_lines = 0;
        exp_err   = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_cursor", 32'(f_cursor), 0);
        chk("midrst_line_cnt", 32'(line_cnt), 0);
        chk("midrst_err", 32'(err), 0);
        chk("midrst_src_ready", 32'(src_ready), 0);
        out_ready = 1'b1;
        reset     = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_rst_src_ready", 32'(src_ready), 1);
        chk("post_rst_out_valid", 32'(out_valid), 0);
        idle_cycles(3);
        run_pixel(16'h00F0, 2, 1, 16'h0F0F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/filter_px_feeder.md
FILTER_PX_FEEDER -- requirements
Module: filter_px_feeder

Interface
REQ-001 SHALL have parameter BLOCK_LENGTH, default 720: pixels per line and the cursor wrap point.
REQ-002 SHALL have parameter RDY_TIMEOUT, default 15: maximum WAIT_RDY cycles before abort.
REQ-003 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-004 SHALL have port reset, input, 1 bit: one clock; reset is synchronous and active-low (reset==0 resets on the next clk rising edge).
REQ-005 SHALL have port src_data, input, 16 bits: RGB565 source pixel.
REQ-006 SHALL have port src_valid, input, 1 bit: source pixel available.
REQ-007 SHALL have port src_ready, output, 1 bit: pixel accepted when src_valid&src_ready at a rising edge.
REQ-008 SHALL have port f_d_in, output, 16 bits: pixel to filter d_in.
REQ-009 SHALL have port f_wren, output, 1 bit: filter write enable.
REQ-010 SHALL have port f_cursor, output, 10 bits: filter cursor (pixel column).
REQ-011 SHALL have port f_d_out, input, 16 bits: filtered pixel from filter.
REQ-012 SHALL have port f_d_rdy, input, 1 bit: filter data-ready.
REQ-013 SHALL have port out_data, output, 16 bits: filtered pixel to sink.
REQ-014 SHALL have port out_valid, output, 1 bit: out_data valid.
REQ-015 SHALL have port out_ready, input, 1 bit: sink accepts when out_valid&out_ready.
REQ-016 SHALL have port line_done, output, 1 bit: one-cycle pulse on the last pixel of a line.
REQ-017 SHALL have port line_cnt, output, 10 bits: completed-line counter.
REQ-018 SHALL have port err, output, 1 bit: sticky d_rdy timeout flag.

Function
REQ-019 SHALL implement states IDLE, WRITE, WAIT_RDY, HOLD_OUT, all outputs registered.
REQ-020 SHALL drive src_ready=1 only in IDLE and 0 in every other state.
REQ-021 SHALL, in IDLE on src_valid=1, latch src_data into f_d_in and enter WRITE.
REQ-022 SHALL assert f_wren=1 for exactly the one WRITE cycle, with f_cursor holding the current column, then enter WAIT_RDY.
REQ-023 SHALL hold f_wren=0 and f_d_in, f_cursor stable in WAIT_RDY and HOLD_OUT.
REQ-024 SHALL ignore f_d_rdy in IDLE and WRITE.
REQ-025 SHALL, in WAIT_RDY, on f_d_rdy=1 capture f_d_out into out_data, set out_valid=1 and enter HOLD_OUT.
REQ-026 SHALL count WAIT_RDY cycles; on reaching RDY_TIMEOUT without f_d_rdy, set err=1, out_data=16'h0000, out_valid=1 and enter HOLD_OUT.
REQ-027 SHALL keep out_valid and out_data stable in HOLD_OUT until out_ready=1.
REQ-028 SHALL, on the out_valid&out_ready cycle, clear out_valid, advance the cursor and return to IDLE.
REQ-029 SHALL advance the cursor by +1, wrapping from BLOCK_LENGTH-1 to 0.
REQ-030 SHALL pulse line_done for one cycle on the wrap and increment line_cnt, wrapping modulo 1024.
REQ-031 SHALL give a minimum latency of 3 cycles from src accept to out_valid (WRITE at T+1, f_d_rdy sampled at T+2, out_valid at T+3) and a throughput of at most 1 pixel per 4 cycles.
REQ-032 SHALL keep err set until reset; it SHALL NOT stall processing.

Reset
REQ-033 SHALL, on reset==0 at a rising edge, enter IDLE and clear f_d_in, f_wren, f_cursor, out_data, out_valid, line_done, line_cnt, err and the timeout counter, regardless of the current state.
REQ-034 SHALL hold src_ready=0 while reset==0, assert it in the first cycle after release, and drop an in-flight pixel without emitting it.

Verification
REQ-035 Single pixel: src_data=16'h1234 accepted at T, f_d_rdy=1 at T+2 with f_d_out=16'hABCD, out_ready=1 -> f_wren=1 only at T+1 with f_cursor=0; out_valid=1 at T+3 with out_data=16'hABCD; f_cursor=1 afterwards.
REQ-036 Line wrap: stream 720 pixels -> f_cursor runs 0..719; line_done pulses once on pixel 719; line_cnt=1; next f_cursor=0.
REQ-037 Backpressure: out_ready=0 for 10 cycles after out_valid -> out_data stable, src_ready=0, f_wren=0 throughout; pixel completes when out_ready=1.
REQ-038 Timeout: f_d_rdy held 0 -> after 15 WAIT_RDY cycles err=1, out_data=16'h0000, out_valid=1; the next pixel still processes normally and err stays 1.
REQ-039 Reset mid-operation: reset=0 during HOLD_OUT with f_cursor=5 -> next cycle IDLE, out_valid=0, f_cursor=0, line_cnt=0, err=0; no stale output after release.
REQ-040 Spurious f_d_rdy=1 in IDLE/WRITE -> no out_valid, no state change.
